// File: rtl/bullet_hit_tracker_pkg.sv
// Shared types and default constants for the bullet hit tracker.
package hit_pkg;

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD, GAME_OVER} hit_state_t;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned DIST_W  = 11;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMER_W = 8;

  localparam int unsigned MAX_HEALTH_DEF     = 4;
  localparam int unsigned LIVES_DEF          = 3;
  localparam int unsigned INVULN_FRAMES_DEF  = 30;
  localparam int unsigned RESPAWN_FRAMES_DEF = 60;
  localparam int unsigned FLASH_SHIFT_DEF    = 2;

endpackage

// File: rtl/bullet_hit_tracker_box_overlap.sv
// Combinational overlap test of two centre/half-size boxes; touching edges count as overlap.
module box_overlap
  import hit_pkg::*;
(
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] a_s,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  input  logic [COORD_W-1:0] b_s,
  output logic               overlap
);

  function automatic logic [DIST_W-1:0] abs_diff(input logic [COORD_W-1:0] p,
                                                  input logic [COORD_W-1:0] q);
    return (p >= q) ? (DIST_W'(p) - DIST_W'(q)) : (DIST_W'(q) - DIST_W'(p));
  endfunction

  logic [DIST_W-1:0] dx;
  logic [DIST_W-1:0] dy;
  logic [DIST_W-1:0] reach;

  // Axis distances and combined reach, all widened so nothing wraps
  always_comb begin
    dx      = abs_diff(a_x, b_x);
    dy      = abs_diff(a_y, b_y);
    reach   = DIST_W'(a_s) + DIST_W'(b_s);
    overlap = (dx <= reach) && (dy <= reach);
  end

endmodule

// File: rtl/bullet_hit_tracker.sv
// Target-side hit responder: overlap test, life-cycle FSM, health/lives counters.
// Optional macro HIT_FLASH_EN: sprite blinks while invulnerable.
module bullet_hit_tracker
  import hit_pkg::*;
#(
  parameter int unsigned MAX_HEALTH     = MAX_HEALTH_DEF,
  parameter int unsigned LIVES          = LIVES_DEF,
  parameter int unsigned INVULN_FRAMES  = INVULN_FRAMES_DEF,
`ifdef HIT_FLASH_EN
  parameter int unsigned FLASH_SHIFT    = FLASH_SHIFT_DEF,
`endif
  parameter int unsigned RESPAWN_FRAMES = RESPAWN_FRAMES_DEF
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               bullet_on,
  input  logic [COORD_W-1:0] BulletX,
  input  logic [COORD_W-1:0] BulletY,
  input  logic [COORD_W-1:0] BulletS,
  input  logic [COORD_W-1:0] TargetX,
  input  logic [COORD_W-1:0] TargetY,
  input  logic [COORD_W-1:0] TargetS,
  output logic               bullet_kill,
  output logic [CNT_W-1:0]   health,
  output logic [CNT_W-1:0]   lives,
  output logic               target_visible,
  output logic               respawn,
  output logic               game_over
);

  hit_state_t         state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0]   health_nxt, lives_nxt;
  logic               kill_nxt, respawn_nxt, game_over_nxt, visible_nxt;
  logic               overlap_c;
  logic               hit_c;

  box_overlap u_box_overlap (
    .a_x     (BulletX),
    .a_y     (BulletY),
    .a_s     (BulletS),
    .b_x     (TargetX),
    .b_y     (TargetY),
    .b_s     (TargetS),
    .overlap (overlap_c)
  );

  assign hit_c = bullet_on & overlap_c;

  // State, timer, counters and all outputs registered together
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state          <= ALIVE;
      timer          <= '0;
      health         <= CNT_W'(MAX_HEALTH);
      lives          <= CNT_W'(LIVES);
      bullet_kill    <= 1'b0;
      respawn        <= 1'b0;
      game_over      <= 1'b0;
      target_visible <= 1'b1;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      health         <= health_nxt;
      lives          <= lives_nxt;
      bullet_kill    <= kill_nxt;
      respawn        <= respawn_nxt;
      game_over      <= game_over_nxt;
      target_visible <= visible_nxt;
    end
  end

  // Life-cycle transitions; timers run down to 1 and leave on that edge
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    health_nxt    = health;
    lives_nxt     = lives;
    kill_nxt      = 1'b0;
    respawn_nxt   = 1'b0;
    game_over_nxt = game_over;
    visible_nxt   = target_visible;

    case (state)
      ALIVE: begin
        if (hit_c) begin
          kill_nxt = 1'b1;
          if (health <= CNT_W'(1)) begin
            health_nxt  = '0;
            lives_nxt   = (lives != '0) ? (lives - CNT_W'(1)) : lives;
            visible_nxt = 1'b0;
            if (lives <= CNT_W'(1)) begin
              state_nxt     = GAME_OVER;
              game_over_nxt = 1'b1;
              timer_nxt     = '0;
            end else begin
              state_nxt = DEAD;
              timer_nxt = TIMER_W'(RESPAWN_FRAMES);
            end
          end else begin
            health_nxt = health - CNT_W'(1);
            state_nxt  = INVULN;
            timer_nxt  = TIMER_W'(INVULN_FRAMES);
          end
        end
      end
      INVULN: begin
        if (timer <= TIMER_W'(1)) begin
          state_nxt   = ALIVE;
          timer_nxt   = '0;
          visible_nxt = 1'b1;
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end
      DEAD: begin
        visible_nxt = 1'b0;
        if (timer <= TIMER_W'(1)) begin
          state_nxt   = ALIVE;
          timer_nxt   = '0;
          health_nxt  = CNT_W'(MAX_HEALTH);
          respawn_nxt = 1'b1;
          visible_nxt = 1'b1;
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end
      default: begin
        game_over_nxt = 1'b1;
        visible_nxt   = 1'b0;
      end
    endcase

`ifdef HIT_FLASH_EN
    if (state_nxt == INVULN) begin
      visible_nxt = ~timer_nxt[FLASH_SHIFT];
    end
`endif
  end

endmodule
